// File: rtl/i2c_target_byte.sv
// I2C target byte engine: address match, write-data and read-data handshakes,
// ACK/NACK generation and optional SCL stretching, driven by a bus filter front end.
module i2c_target_byte #(
    parameter int STRETCH_EN = 1
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       sta_det,
    input  logic       sto_det,
    input  logic       scl_rising,
    input  logic       scl_faling,
    input  logic       sda_i,
    output logic       sda_o,
    output logic       scl_o,
    input  logic [6:0] own_addr,
    output logic       addr_hit,
    output logic       rw,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       stop_evt,
    output logic       active
);
    localparam bit STR = (STRETCH_EN != 0);

    typedef enum logic [2:0] {
        IDLE, ADDR, ADDR_ACK, RX, RX_ACK, TX, TX_ACK, WAIT_STO
    } state_t;

    state_t     state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic [7:0] sreg_q, sreg_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic       ph_q, ph_d;      // second half of an ACK slot / stretch in progress
    logic       pend_q, pend_d;  // received byte still waiting for a free rx_data
    logic       sda_q, sda_d, scl_q, scl_d;
    logic       rx_valid_q, rx_valid_d, tx_ready_q, tx_ready_d;
    logic       addr_hit_q, addr_hit_d, rw_q, rw_d;
    logic       stop_q, stop_d, active_q, active_d;
    logic       start_tx;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= IDLE;
            cnt_q      <= 3'd0;
            sreg_q     <= 8'h00;
            rx_data_q  <= 8'h00;
            ph_q       <= 1'b0;
            pend_q     <= 1'b0;
            sda_q      <= 1'b1;
            scl_q      <= 1'b1;
            rx_valid_q <= 1'b0;
            tx_ready_q <= 1'b0;
            addr_hit_q <= 1'b0;
            rw_q       <= 1'b0;
            stop_q     <= 1'b0;
            active_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            sreg_q     <= sreg_d;
            rx_data_q  <= rx_data_d;
            ph_q       <= ph_d;
            pend_q     <= pend_d;
            sda_q      <= sda_d;
            scl_q      <= scl_d;
            rx_valid_q <= rx_valid_d;
            tx_ready_q <= tx_ready_d;
            addr_hit_q <= addr_hit_d;
            rw_q       <= rw_d;
            stop_q     <= stop_d;
            active_q   <= active_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        sreg_d     = sreg_q;
        rx_data_d  = rx_data_q;
        ph_d       = ph_q;
        pend_d     = pend_q;
        sda_d      = sda_q;
        scl_d      = scl_q;
        rx_valid_d = rx_valid_q;
        tx_ready_d = tx_ready_q;
        rw_d       = rw_q;
        active_d   = active_q;
        addr_hit_d = 1'b0;
        stop_d     = 1'b0;
        start_tx   = 1'b0;
        if (rx_ready) rx_valid_d = 1'b0;

        if (sta_det || sto_det) begin
            state_d    = sta_det ? ADDR : IDLE;
            cnt_d      = 3'd0;
            ph_d       = 1'b0;
            pend_d     = 1'b0;
            sda_d      = 1'b1;
            scl_d      = 1'b1;
            tx_ready_d = 1'b0;
            stop_d     = active_q;
            active_d   = 1'b0;
        end else begin
            case (state_q)
                ADDR: if (scl_rising) begin
                    sreg_d = {sreg_q[6:0], sda_i};
                    cnt_d  = cnt_q + 3'd1;
                    if (cnt_q == 3'd7) begin
                        if (sreg_q[6:0] == own_addr) begin
                            addr_hit_d = 1'b1;
                            rw_d       = sda_i;
                            active_d   = 1'b1;
                            ph_d       = 1'b0;
                            state_d    = ADDR_ACK;
                        end else begin
                            state_d = WAIT_STO;
                        end
                    end
                end
                ADDR_ACK: if (scl_faling) begin
                    if (!ph_q) begin
                        sda_d = 1'b0;
                        ph_d  = 1'b1;
                    end else begin
                        ph_d  = 1'b0;
                        cnt_d = 3'd0;
                        if (rw_q) start_tx = 1'b1;
                        else begin
                            sda_d   = 1'b1;
                            state_d = RX;
                        end
                    end
                end
                RX: if (scl_rising) begin
                    sreg_d = {sreg_q[6:0], sda_i};
                    cnt_d  = cnt_q + 3'd1;
                    if (cnt_q == 3'd7) begin
                        state_d = RX_ACK;
                        ph_d    = 1'b0;
                        if (!rx_valid_q || rx_ready) begin
                            rx_data_d  = {sreg_q[6:0], sda_i};
                            rx_valid_d = 1'b1;
                            pend_d     = 1'b0;
                        end else begin
                            pend_d = 1'b1;
                        end
                    end
                end
                RX_ACK: begin
                    if (!ph_q) begin
                        if (scl_faling) begin
                            if (!pend_q) begin
                                sda_d = 1'b0;
                                ph_d  = 1'b1;
                            end else if (STR) begin
                                scl_d = 1'b0;
                                ph_d  = 1'b1;
                            end else begin
                                pend_d  = 1'b0;
                                state_d = WAIT_STO;
                            end
                        end
                    end else if (pend_q) begin
                        // SCL is held low here, so ACK may change off a falling edge
                        if (!rx_valid_q) begin
                            rx_data_d  = sreg_q;
                            rx_valid_d = 1'b1;
                            pend_d     = 1'b0;
                            sda_d      = 1'b0;
                            scl_d      = 1'b1;
                        end
                    end else if (scl_faling) begin
                        sda_d   = 1'b1;
                        cnt_d   = 3'd0;
                        ph_d    = 1'b0;
                        state_d = RX;
                    end
                end
                TX: begin
                    if (tx_ready_q && tx_valid && !scl_rising) begin
                        sreg_d     = tx_data;
                        sda_d      = tx_data[7];
                        tx_ready_d = 1'b0;
                        scl_d      = 1'b1;
                    end else begin
                        // a rising edge with no load means the 0xFF default goes out
                        if (scl_rising) begin
                            cnt_d      = cnt_q + 3'd1;
                            tx_ready_d = 1'b0;
                            scl_d      = 1'b1;
                        end
                        if (scl_faling) begin
                            if (cnt_q == 3'd0) begin
                                sda_d   = 1'b1;
                                ph_d    = 1'b0;
                                state_d = TX_ACK;
                            end else begin
                                sreg_d = {sreg_q[6:0], 1'b0};
                                sda_d  = sreg_q[6];
                            end
                        end
                    end
                end
                TX_ACK: begin
                    if (scl_rising && !ph_q) begin
                        if (sda_i) state_d = WAIT_STO;
                        else       ph_d    = 1'b1;
                    end else if (scl_faling && ph_q) begin
                        ph_d     = 1'b0;
                        start_tx = 1'b1;
                    end
                end
                default: ;
            endcase

            if (start_tx) begin
                state_d    = TX;
                cnt_d      = 3'd0;
                tx_ready_d = 1'b1;
                sda_d      = 1'b1;
                sreg_d     = 8'hFF;
                scl_d      = !STR;
            end
        end
    end

    assign sda_o    = sda_q;
    assign scl_o    = scl_q;
    assign addr_hit = addr_hit_q;
    assign rw       = rw_q;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign tx_ready = tx_ready_q;
    assign stop_evt = stop_q;
    assign active   = active_q;

endmodule

// File: tb/tb_i2c_target_byte.sv
// Bench: bit-banged I2C master against a stretching and a non-stretching target,
// with a scoreboard monitor for addr_hit, rx handshakes and stop_evt.
module tb_i2c_target_byte;
    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    logic sta = 0, sto = 0, sr = 0, sf = 0, m_sda = 1, sel = 0;
    logic [6:0] own_addr = 7'h50;
    logic rx_ready = 0, tx_valid = 0;
    logic [7:0] tx_data = 8'h00;

    logic sda_o1, scl_o1, addr_hit1, rw1, rx_valid1, tx_ready1, stop1, active1;
    logic sda_o0, scl_o0, addr_hit0, rw0, rx_valid0, tx_ready0, stop0, active0;
    logic [7:0] rx_data1, rx_data0;
    logic sda_i1, sda_i0;
    assign sda_i1 = m_sda & sda_o1;
    assign sda_i0 = m_sda & sda_o0;

    i2c_target_byte #(.STRETCH_EN(1)) dut1 (
        .clk(clk), .rstn(rstn), .sta_det(sta & ~sel), .sto_det(sto & ~sel),
        .scl_rising(sr & ~sel), .scl_faling(sf & ~sel), .sda_i(sda_i1),
        .sda_o(sda_o1), .scl_o(scl_o1), .own_addr(own_addr),
        .addr_hit(addr_hit1), .rw(rw1), .rx_data(rx_data1), .rx_valid(rx_valid1),
        .rx_ready(rx_ready), .tx_data(tx_data), .tx_valid(tx_valid & ~sel),
        .tx_ready(tx_ready1), .stop_evt(stop1), .active(active1));

    i2c_target_byte #(.STRETCH_EN(0)) dut0 (
        .clk(clk), .rstn(rstn), .sta_det(sta & sel), .sto_det(sto & sel),
        .scl_rising(sr & sel), .scl_faling(sf & sel), .sda_i(sda_i0),
        .sda_o(sda_o0), .scl_o(scl_o0), .own_addr(own_addr),
        .addr_hit(addr_hit0), .rw(rw0), .rx_data(rx_data0), .rx_valid(rx_valid0),
        .rx_ready(rx_ready), .tx_data(tx_data), .tx_valid(tx_valid & sel),
        .tx_ready(tx_ready0), .stop_evt(stop0), .active(active0));

    logic sda_o_m, scl_o_m, addr_hit_m, rw_m, rx_valid_m, tx_ready_m, stop_m, active_m, sda_m;
    logic [7:0] rx_data_m;
    assign sda_o_m    = sel ? sda_o0    : sda_o1;
    assign scl_o_m    = sel ? scl_o0    : scl_o1;
    assign addr_hit_m = sel ? addr_hit0 : addr_hit1;
    assign rw_m       = sel ? rw0       : rw1;
    assign rx_valid_m = sel ? rx_valid0 : rx_valid1;
    assign rx_data_m  = sel ? rx_data0  : rx_data1;
    assign tx_ready_m = sel ? tx_ready0 : tx_ready1;
    assign stop_m     = sel ? stop0     : stop1;
    assign active_m   = sel ? active0   : active1;
    assign sda_m      = sel ? sda_i0    : sda_i1;

    int n_cmp = 0, n_bad = 0;
    logic [7:0] q_rx[$];
    logic       q_hit[$];
    logic       q_stop[$];
    logic [7:0] q_tx[$];
    logic low_seen = 0, scl_low_seen = 0;
    int tx_delay = 2, lows, k;
    logic chk_stretch = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic unexpected(input string nm, input logic [31:0] act);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: got %0h with nothing expected", nm, act);
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents an event.
    initial forever begin
        @(negedge clk); #1;
        if (rx_valid_m && rx_ready) begin
            if (q_rx.size() == 0) unexpected("rx_data", {24'd0, rx_data_m});
            else chk("rx_data", {24'd0, rx_data_m}, {24'd0, q_rx.pop_front()});
        end
        if (addr_hit_m) begin
            if (q_hit.size() == 0) unexpected("addr_hit", {31'd0, rw_m});
            else chk("addr_hit_rw_active", {30'd0, rw_m, active_m}, {30'd0, q_hit.pop_front(), 1'b1});
        end
        if (stop_m) begin
            if (q_stop.size() == 0) unexpected("stop_evt", 32'd1);
            else begin
                void'(q_stop.pop_front());
                chk("stop_evt_active_clear", {31'd0, active_m}, 32'd0);
            end
        end
        if (!sda_o_m) low_seen = 1;
        if (!scl_o_m) scl_low_seen = 1;
    end

    // Read-data source: answers tx_ready after tx_delay cycles, counting stretched cycles.
    initial forever begin
        @(negedge clk); #2;
        if (tx_ready_m && !tx_valid) begin
            lows = 0;
            for (int i = 0; i < tx_delay; i++) begin
                if (!scl_o_m) lows++;
                @(negedge clk); #2;
            end
            if (chk_stretch) begin
                chk("tx_stretch_cycles", lows, tx_delay);
                chk_stretch = 0;
            end
            tx_data  = (q_tx.size() != 0) ? q_tx.pop_front() : 8'h00;
            tx_valid = 1;
            k = 0;
            while (tx_ready_m && k < 100) begin
                @(negedge clk); #2;
                k++;
            end
            tx_valid = 0;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_sta;
        sta = 1; tick(1); sta = 0; tick(2);
    endtask

    task automatic pulse_sto;
        sto = 1; tick(1); sto = 0; tick(2);
    endtask

    task automatic fall;
        sf = 1; tick(1); sf = 0; tick(1);
    endtask

    task automatic wait_scl;
        int n = 0;
        while (!scl_o_m && n < 300) begin
            tick(1);
            n++;
        end
        if (!scl_o_m) unexpected("scl_release_timeout", 32'd0);
    endtask

    task automatic rise;
        wait_scl();
        sr = 1; tick(1); sr = 0; tick(1);
    endtask

    task automatic send_bit(input logic b);
        fall(); m_sda = b; tick(2); rise();
    endtask

    task automatic rd_bit(output logic b);
        fall(); m_sda = 1; tick(2); wait_scl(); tick(1);
        b = sda_m;
        rise();
    endtask

    task automatic send_bits(input logic [7:0] d);
        for (int i = 7; i >= 0; i--) send_bit(d[i]);
    endtask

    task automatic send_byte(input logic [7:0] d, output logic ack);
        send_bits(d);
        rd_bit(ack);
    endtask

    task automatic rd_byte(output logic [7:0] d);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            rd_bit(b);
            d[i] = b;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: run did not complete");
        n_bad++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1);
    end

    initial begin
        logic ack, b;
        logic [7:0] d;
        tick(3);
        chk("rst_sda_o", {31'd0, sda_o1}, 1);
        chk("rst_scl_o", {31'd0, scl_o1}, 1);
        chk("rst_rx_data", {24'd0, rx_data1}, 0);
        chk("rst_rx_valid", {31'd0, rx_valid1}, 0);
        chk("rst_tx_ready", {31'd0, tx_ready1}, 0);
        chk("rst_addr_hit", {31'd0, addr_hit1}, 0);
        chk("rst_rw", {31'd0, rw1}, 0);
        chk("rst_stop_evt", {31'd0, stop1}, 0);
        chk("rst_active", {31'd0, active1}, 0);
        chk("rst0_lines", {30'd0, sda_o0, scl_o0}, 3);
        rstn = 1;
        tick(2);

        // addressed write
        rx_ready = 1; scl_low_seen = 0;
        q_hit.push_back(0);
        pulse_sta();
        send_byte(8'hA0, ack); chk("t1_addr_ack", {31'd0, ack}, 0);
        q_rx.push_back(8'h3C);
        send_byte(8'h3C, ack); chk("t1_data_ack", {31'd0, ack}, 0);
        chk("t1_rw", {31'd0, rw_m}, 0);
        fall();
        q_stop.push_back(1);
        pulse_sto(); tick(2);
        chk("t1_active_after_stop", {31'd0, active_m}, 0);
        chk("t1_scl_never_low", {31'd0, scl_low_seen}, 0);

        // address miss
        low_seen = 0;
        pulse_sta();
        send_byte(8'hA2, ack); chk("t2_addr_nack", {31'd0, ack}, 1);
        send_byte(8'h55, ack);
        chk("t2_sda_never_low", {31'd0, low_seen}, 0);
        chk("t2_active", {31'd0, active_m}, 0);
        fall(); pulse_sto(); tick(2);

        // read with a 20-cycle stretch on the first byte
        q_hit.push_back(1);
        pulse_sta();
        send_byte(8'hA1, ack); chk("t3_addr_ack", {31'd0, ack}, 0);
        q_tx.push_back(8'h5A); q_tx.push_back(8'hC3);
        tx_delay = 20; chk_stretch = 1;
        rd_byte(d); chk("t3_byte1", {24'd0, d}, 32'h5A);
        send_bit(0);
        tx_delay = 2;
        rd_byte(d); chk("t3_byte2", {24'd0, d}, 32'hC3);
        send_bit(1);
        tick(4); chk("t3_tx_ready_after_nack", {31'd0, tx_ready_m}, 0);
        fall(); tick(3);
        chk("t3_tx_ready_wait_sto", {31'd0, tx_ready_m}, 0);
        chk("t3_sda_released", {31'd0, sda_o_m}, 1);
        q_stop.push_back(1);
        pulse_sto(); tick(2);

        // rx back-pressure, stretching target
        rx_ready = 0;
        q_hit.push_back(0);
        pulse_sta();
        send_byte(8'hA0, ack); chk("t4_addr_ack", {31'd0, ack}, 0);
        q_rx.push_back(8'h11);
        send_byte(8'h11, ack); chk("t4_byte1_ack", {31'd0, ack}, 0);
        q_rx.push_back(8'h22);
        send_bits(8'h22);
        fork
            rd_bit(ack);
            begin
                tick(12);
                chk("t4_scl_stretch", {31'd0, scl_o_m}, 0);
                rx_ready = 1; tick(1); rx_ready = 0;
            end
        join
        chk("t4_byte2_ack", {31'd0, ack}, 0);
        fall();
        q_stop.push_back(1);
        pulse_sto(); tick(2);
        rx_ready = 1; tick(1); rx_ready = 0; tick(2);
        chk("t4_rx_valid_drained", {31'd0, rx_valid_m}, 0);

        // rx back-pressure, non-stretching target
        sel = 1; tick(2);
        q_hit.push_back(0);
        pulse_sta();
        send_byte(8'hA0, ack); chk("t5_addr_ack", {31'd0, ack}, 0);
        q_rx.push_back(8'h11);
        send_byte(8'h11, ack); chk("t5_byte1_ack", {31'd0, ack}, 0);
        send_byte(8'h22, ack); chk("t5_byte2_nack", {31'd0, ack}, 1);
        fall();
        q_stop.push_back(1);
        pulse_sto(); tick(2);
        rx_ready = 1; tick(1); rx_ready = 0; tick(2);
        chk("t5_rx_valid_drained", {31'd0, rx_valid_m}, 0);
        sel = 0; tick(2);

        // repeated START: write then read
        rx_ready = 1;
        q_hit.push_back(0);
        pulse_sta();
        send_byte(8'hA0, ack); chk("t6_addr_ack", {31'd0, ack}, 0);
        q_rx.push_back(8'h77);
        send_byte(8'h77, ack); chk("t6_data_ack", {31'd0, ack}, 0);
        fall();
        q_stop.push_back(1);
        pulse_sta();
        q_hit.push_back(1);
        send_byte(8'hA1, ack); chk("t6_sr_addr_ack", {31'd0, ack}, 0);
        chk("t6_rw", {31'd0, rw_m}, 1);
        q_tx.push_back(8'h96);
        rd_byte(d); chk("t6_read_byte", {24'd0, d}, 32'h96);
        send_bit(1);
        q_stop.push_back(1);
        pulse_sto(); tick(2);

        // reset in the middle of a read
        q_hit.push_back(1);
        pulse_sta();
        send_byte(8'hA1, ack); chk("t7_addr_ack", {31'd0, ack}, 0);
        q_tx.push_back(8'h00);
        rd_bit(b); chk("t7_first_bit", {31'd0, b}, 0);
        chk("t7_sda_low_pre_reset", {31'd0, sda_o_m}, 0);
        #3 rstn = 0;
        #1;
        chk("t7_sda_async_release", {31'd0, sda_o_m}, 1);
        chk("t7_scl_async_release", {31'd0, scl_o_m}, 1);
        @(negedge clk); tick(1);
        rstn = 1; tick(2);
        low_seen = 0; scl_low_seen = 0;
        rd_byte(d);
        send_bits(8'hA1);
        chk("t7_bus_idle_byte", {24'd0, d}, 32'hFF);
        chk("t7_sda_never_low", {31'd0, low_seen}, 0);
        chk("t7_scl_never_low", {31'd0, scl_low_seen}, 0);
        chk("t7_active", {31'd0, active_m}, 0);
        chk("t7_tx_ready", {31'd0, tx_ready_m}, 0);
        pulse_sto(); tick(5);

        chk("q_rx_drained", q_rx.size(), 0);
        chk("q_hit_drained", q_hit.size(), 0);
        chk("q_stop_drained", q_stop.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
